// File: rtl/iot_sequencer.sv
// IOT path controller: decodes an IOT instruction, sequences timed IOP1/IOP2/IOP4
// pulses to the peripherals, merges their responses and owns the interrupt enable.
//
// state  | meaning
// IDLE   | waiting for an IOT start
// P1     | IOP1 phase, PULSE_CYCLES long
// P2     | IOP2 phase, PULSE_CYCLES long
// P4     | IOP4 phase, PULSE_CYCLES long
// DONE   | one-cycle result/done; device 00 ops take effect here
module iot_sequencer #(
    parameter int NDEV         = 4,
    parameter int PULSE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iot_start,
    input  logic [0:11]          instruction,
    input  logic                 instr_done,
    input  logic                 int_ack,
    input  logic [NDEV-1:0]      dev_skip,
    input  logic [NDEV*12-1:0]   dev_data,
    input  logic [NDEV-1:0]      dev_data_valid,
    input  logic [NDEV-1:0]      dev_clr_ac,
    input  logic [NDEV-1:0]      dev_irq,
    output logic [0:5]           dev_select,
    output logic                 iop1,
    output logic                 iop2,
    output logic                 iop4,
    output logic                 busy,
    output logic                 iot_done,
    output logic                 skip,
    output logic                 clear_ac,
    output logic [0:11]          in_bus,
    output logic                 int_enable,
    output logic                 int_req
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_P1   = 3'd1;
    localparam logic [2:0] S_P2   = 3'd2;
    localparam logic [2:0] S_P4   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0] PHASE_LOAD = 4'(PULSE_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  next_phase;
    logic [3:0]  phase_cnt;
    logic [2:0]  iop_en;       // [0]=IOP1, [1]=IOP2, [2]=IOP4
    logic [2:0]  op_code;
    logic        dev_zero;
    logic        skip_acc;
    logic        clr_acc;
    logic [11:0] data_acc;
    logic [11:0] data_or;
    logic        done_skip;
    logic        start_ok;
    logic        iop_active;
    logic        phase_end;
    logic        ion_delay;

    assign start_ok   = iot_start && (state == S_IDLE) && (instruction[0:2] == 3'o6);
    assign iop1       = (state == S_P1) && iop_en[0];
    assign iop2       = (state == S_P2) && iop_en[1];
    assign iop4       = (state == S_P4) && iop_en[2];
    assign busy       = (state == S_P1) || (state == S_P2) || (state == S_P4);
    assign iot_done   = (state == S_DONE);
    assign iop_active = iop1 || iop2 || iop4;
    assign phase_end  = (phase_cnt == 4'd0);

    always_comb begin
        data_or = '0;
        for (int k = 0; k < NDEV; k++) begin
            if (dev_data_valid[k]) begin
                data_or = data_or | dev_data[12*k +: 12];
            end
        end
    end

    always_comb begin
        case (state)
            S_P1:    next_phase = S_P2;
            S_P2:    next_phase = S_P4;
            default: next_phase = S_DONE;
        endcase
    end

    // Device 00 skip results must be visible during the DONE cycle itself.
    always_comb begin
        done_skip = 1'b0;
        if (dev_zero) begin
            case (op_code)
                3'o0:    done_skip = int_enable;
                3'o3:    done_skip = |dev_irq;
                default: done_skip = 1'b0;
            endcase
        end
    end

    assign skip     = (iot_done && dev_zero) ? done_skip : skip_acc;
    assign clear_ac = clr_acc;
    assign in_bus   = data_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            phase_cnt  <= 4'd0;
            iop_en     <= 3'b000;
            op_code    <= 3'o0;
            dev_zero   <= 1'b0;
            dev_select <= 6'o00;
            skip_acc   <= 1'b0;
            clr_acc    <= 1'b0;
            data_acc   <= 12'o0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        dev_select <= instruction[3:8];
                        dev_zero   <= (instruction[3:8] == 6'o00);
                        op_code    <= instruction[9:11];
                        iop_en     <= {instruction[9], instruction[10], instruction[11]};
                        skip_acc   <= 1'b0;
                        clr_acc    <= 1'b0;
                        data_acc   <= 12'o0000;
                        phase_cnt  <= PHASE_LOAD;
                        state      <= (instruction[3:8] == 6'o00) ? S_DONE : S_P1;
                    end
                end
                S_P1, S_P2, S_P4: begin
                    if (iop_active) begin
                        skip_acc <= skip_acc | (|dev_skip);
                        clr_acc  <= clr_acc | (|dev_clr_ac);
                        data_acc <= data_acc | data_or;
                    end
                    if (phase_end) begin
                        phase_cnt <= PHASE_LOAD;
                        state     <= next_phase;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (dev_zero) begin
                        skip_acc <= done_skip;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Later assignments take priority: ION/IOF override the delayed enable, int_ack overrides all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_enable <= 1'b0;
            ion_delay  <= 1'b0;
            int_req    <= 1'b0;
        end else begin
            if (ion_delay && instr_done) begin
                int_enable <= 1'b1;
                ion_delay  <= 1'b0;
            end
            if (iot_done && dev_zero) begin
                case (op_code)
                    3'o0: int_enable <= 1'b0;
                    3'o1: ion_delay  <= 1'b1;
                    3'o2: begin
                        int_enable <= 1'b0;
                        ion_delay  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (int_ack) begin
                int_enable <= 1'b0;
                ion_delay  <= 1'b0;
            end
            int_req <= int_enable & (|dev_irq) & ~busy;
        end
    end

endmodule

// File: tb/tb_iot_sequencer.sv
// Bench for iot_sequencer: two instances (PULSE_CYCLES 1 and 3) share stimulus and are
// compared every cycle against a timeline-based reference model.
module tb_iot_sequencer;

    localparam int NDEV = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               iot_start;
    logic [0:11]        instruction;
    logic               instr_done;
    logic               int_ack;
    logic [NDEV-1:0]    dev_skip;
    logic [NDEV*12-1:0] dev_data;
    logic [NDEV-1:0]    dev_data_valid;
    logic [NDEV-1:0]    dev_clr_ac;
    logic [NDEV-1:0]    dev_irq;

    logic [0:5]  o_sel  [2];
    logic        o_iop1 [2];
    logic        o_iop2 [2];
    logic        o_iop4 [2];
    logic        o_busy [2];
    logic        o_done [2];
    logic        o_skip [2];
    logic        o_clr  [2];
    logic [0:11] o_bus  [2];
    logic        o_ie   [2];
    logic        o_req  [2];

    int n_cmp = 0;
    int n_err = 0;

    // reference model: m_cyc is the cycle number within the current IOT (0 = idle)
    int          m_cyc   [2];
    bit          m_ie    [2];
    bit          m_ion   [2];
    bit          m_req   [2];
    bit          m_skip  [2];
    bit          m_clr   [2];
    logic [11:0] m_bus   [2];
    logic [11:0] m_instr [2];
    logic [5:0]  m_sel   [2];

    always #5 clk = ~clk;

    iot_sequencer #(.NDEV(NDEV), .PULSE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .iot_start(iot_start), .instruction(instruction),
        .instr_done(instr_done), .int_ack(int_ack), .dev_skip(dev_skip), .dev_data(dev_data),
        .dev_data_valid(dev_data_valid), .dev_clr_ac(dev_clr_ac), .dev_irq(dev_irq),
        .dev_select(o_sel[0]), .iop1(o_iop1[0]), .iop2(o_iop2[0]), .iop4(o_iop4[0]),
        .busy(o_busy[0]), .iot_done(o_done[0]), .skip(o_skip[0]), .clear_ac(o_clr[0]),
        .in_bus(o_bus[0]), .int_enable(o_ie[0]), .int_req(o_req[0])
    );

    iot_sequencer #(.NDEV(NDEV), .PULSE_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .iot_start(iot_start), .instruction(instruction),
        .instr_done(instr_done), .int_ack(int_ack), .dev_skip(dev_skip), .dev_data(dev_data),
        .dev_data_valid(dev_data_valid), .dev_clr_ac(dev_clr_ac), .dev_irq(dev_irq),
        .dev_select(o_sel[1]), .iop1(o_iop1[1]), .iop2(o_iop2[1]), .iop4(o_iop4[1]),
        .busy(o_busy[1]), .iot_done(o_done[1]), .skip(o_skip[1]), .clear_ac(o_clr[1]),
        .in_bus(o_bus[1]), .int_enable(o_ie[1]), .int_req(o_req[1])
    );

    function automatic int pc_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit dev0(input int i);
        return m_instr[i][8:3] == 6'o00;
    endfunction

    function automatic int last_cyc(input int i);
        return dev0(i) ? 1 : 3 * pc_of(i) + 1;
    endfunction

    // n = 0,1,2 selects IOP1, IOP2, IOP4 (instruction bits 11, 10, 9)
    function automatic bit iop_exp(input int i, input int n);
        int c;
        int p;
        c = m_cyc[i];
        p = pc_of(i);
        if (c == 0 || dev0(i)) return 1'b0;
        return m_instr[i][n] && (c > n * p) && (c <= (n + 1) * p);
    endfunction

    function automatic logic [11:0] bus_or();
        logic [11:0] r;
        r = '0;
        for (int k = 0; k < NDEV; k++)
            if (dev_data_valid[k]) r = r | dev_data[12*k +: 12];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0;  m_ie[i] = 0;  m_ion[i] = 0;  m_req[i] = 0;
            m_skip[i] = 0; m_clr[i] = 0; m_bus[i] = '0; m_instr[i] = '0; m_sel[i] = '0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int          c;
            bit          ie0;
            bit          busy_now;
            logic [11:0] iv;
            c        = m_cyc[i];
            ie0      = m_ie[i];
            busy_now = (c > 0) && (c < last_cyc(i));
            if (iop_exp(i, 0) || iop_exp(i, 1) || iop_exp(i, 2)) begin
                m_skip[i] = m_skip[i] | (|dev_skip);
                m_clr[i]  = m_clr[i] | (|dev_clr_ac);
                m_bus[i]  = m_bus[i] | bus_or();
            end
            if (m_ion[i] && instr_done) begin
                m_ie[i]  = 1'b1;
                m_ion[i] = 1'b0;
            end
            if (c > 0 && c == last_cyc(i) && dev0(i)) begin
                case (m_instr[i][2:0])
                    3'o0: begin m_skip[i] = ie0; m_ie[i] = 1'b0; end
                    3'o1: m_ion[i] = 1'b1;
                    3'o2: begin m_ie[i] = 1'b0; m_ion[i] = 1'b0; end
                    3'o3: m_skip[i] = |dev_irq;
                    default: ;
                endcase
            end
            if (int_ack) begin
                m_ie[i]  = 1'b0;
                m_ion[i] = 1'b0;
            end
            m_req[i] = ie0 && (|dev_irq) && !busy_now;
            iv = instruction;
            if (c == 0) begin
                if (iot_start && iv[11:9] == 3'o6) begin
                    m_instr[i] = iv;
                    m_sel[i]   = iv[8:3];
                    m_skip[i]  = 1'b0;
                    m_clr[i]   = 1'b0;
                    m_bus[i]   = '0;
                    m_cyc[i]   = 1;
                end
            end else if (c == last_cyc(i)) begin
                m_cyc[i] = 0;
            end else begin
                m_cyc[i] = c + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0o, expected %0o", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int    c;
            bit    d;
            bit    sk;
            string u;
            c  = m_cyc[i];
            d  = (c > 0) && (c == last_cyc(i));
            sk = m_skip[i];
            if (d && dev0(i)) begin
                case (m_instr[i][2:0])
                    3'o0:    sk = m_ie[i];
                    3'o3:    sk = |dev_irq;
                    default: sk = 1'b0;
                endcase
            end
            u = $sformatf("u%0d", pc_of(i));
            chk({u, ".dev_select"}, 12'(o_sel[i]), 12'(m_sel[i]));
            chk({u, ".iop1"},       12'(o_iop1[i]), 12'(iop_exp(i, 0)));
            chk({u, ".iop2"},       12'(o_iop2[i]), 12'(iop_exp(i, 1)));
            chk({u, ".iop4"},       12'(o_iop4[i]), 12'(iop_exp(i, 2)));
            chk({u, ".busy"},       12'(o_busy[i]), 12'((c > 0) && !d));
            chk({u, ".iot_done"},   12'(o_done[i]), 12'(d));
            chk({u, ".skip"},       12'(o_skip[i]), 12'(sk));
            chk({u, ".clear_ac"},   12'(o_clr[i]),  12'(m_clr[i]));
            chk({u, ".in_bus"},     o_bus[i],       m_bus[i]);
            chk({u, ".int_enable"}, 12'(o_ie[i]),   12'(m_ie[i]));
            chk({u, ".int_req"},    12'(o_req[i]),  12'(m_req[i]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        iot_start  = 1'b0;
        instr_done = 1'b0;
        int_ack    = 1'b0;
        check_all();
    endtask

    task automatic launch(input logic [11:0] iv);
        instruction = iv;
        iot_start   = 1'b1;
        step();
    endtask

    task automatic quiet();
        dev_skip       = '0;
        dev_data       = '0;
        dev_data_valid = '0;
        dev_clr_ac     = '0;
    endtask

    task automatic drain();
        quiet();
        for (int k = 0; k < 40 && (m_cyc[0] != 0 || m_cyc[1] != 0); k++) step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] iv;
        int          r;
        reset = 1'b0;
        iot_start = 1'b0; instr_done = 1'b0; int_ack = 1'b0;
        instruction = '0; dev_irq = '0;
        quiet();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset.busy", 12'(o_busy[1]), 12'd0);
        reset = 1'b1;
        step();

        // 6031: skip from slot 0 during IOP1
        launch(12'o6031);
        dev_skip = 4'b0001;
        step();
        dev_skip = '0;
        step();
        step();
        chk("t6031.done", 12'(o_done[0]), 12'd1);
        chk("t6031.skip", 12'(o_skip[0]), 12'd1);
        chk("t6031.in_bus", o_bus[0], 12'o0000);
        drain();

        // 6036: data merged from IOP2 and IOP4 slots
        launch(12'o6036);
        step();
        dev_data[12*1 +: 12] = 12'o0215; dev_data_valid = 4'b0010; dev_clr_ac = 4'b0010;
        step();
        dev_data[12*2 +: 12] = 12'o0040; dev_data_valid = 4'b0100; dev_clr_ac = 4'b0000;
        step();
        quiet();
        chk("t6036.in_bus", o_bus[0], 12'o0255);
        chk("t6036.clear_ac", 12'(o_clr[0]), 12'd1);
        drain();

        // 6034: data while iop1 is inactive is ignored
        launch(12'o6034);
        dev_data[11:0] = 12'o7777; dev_data_valid = 4'b0001;
        step();
        quiet();
        step();
        step();
        chk("t6034.in_bus", o_bus[0], 12'o0000);
        drain();

        // ION with instr_done in the DONE cycle, then delayed enable and int_ack
        dev_irq = 4'b0001;
        launch(12'o6001);
        instr_done = 1'b1;
        step();
        chk("ion.same_cycle", 12'(o_ie[0]), 12'd0);
        step();
        instr_done = 1'b1;
        step();
        chk("ion.enable", 12'(o_ie[1]), 12'd1);
        step();
        chk("ion.int_req", 12'(o_req[0]), 12'd1);
        int_ack = 1'b1;
        step();
        chk("ack.int_enable", 12'(o_ie[0]), 12'd0);
        step();
        chk("ack.int_req", 12'(o_req[1]), 12'd0);

        // SKON with interrupts enabled
        launch(12'o6001);
        step();
        instr_done = 1'b1;
        step();
        launch(12'o6000);
        chk("skon.skip", 12'(o_skip[0]), 12'd1);
        step();
        chk("skon.int_enable", 12'(o_ie[0]), 12'd0);
        dev_irq = '0;
        drain();

        // starts while busy or in DONE are dropped
        launch(12'o6011);
        step();
        iot_start = 1'b1;
        step();
        step();
        iot_start = 1'b1;
        step();
        chk("drop.busy", 12'(o_busy[0]), 12'd0);
        drain();

        // non-IOT opcode is ignored
        launch(12'o7402);
        chk("nonio.busy", 12'(o_busy[0]), 12'd0);
        chk("nonio.done", 12'(o_done[1]), 12'd0);
        drain();

        // asynchronous reset in the middle of the PULSE_CYCLES=3 IOP2 phase
        launch(12'o6047);
        repeat (4) step();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst.mid.busy", 12'(o_busy[1]), 12'd0);
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;
        step();
        launch(12'o6041);
        repeat (9) step();
        chk("t6041.done10", 12'(o_done[1]), 12'd1);
        drain();

        // randomized IOT traffic
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                iv = 12'($urandom);
                if (iv[11:9] == 3'o6) iv[11:9] = 3'o7;
            end else if (r <= 3) begin
                iv = 12'o6000 | 12'($urandom_range(0, 7));
            end else begin
                iv = {3'o6, 6'($urandom_range(1, 63)), 3'($urandom_range(0, 7))};
            end
            if ($urandom_range(0, 3) == 0) dev_irq = 4'($urandom);
            launch(iv);
            for (int k = 0; k < 40 && (m_cyc[0] != 0 || m_cyc[1] != 0); k++) begin
                dev_skip       = 4'($urandom & $urandom);
                dev_data_valid = 4'($urandom & $urandom);
                dev_clr_ac     = 4'($urandom & $urandom & $urandom);
                for (int s = 0; s < NDEV; s++) dev_data[12*s +: 12] = 12'($urandom);
                instr_done = ($urandom_range(0, 3) == 0);
                int_ack    = ($urandom_range(0, 19) == 0);
                iot_start  = ($urandom_range(0, 7) == 0);
                step();
            end
            quiet();
            instr_done = ($urandom_range(0, 1) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iot_sequencer.md
Name: iot_sequencer

Overview:
- Controller for the CPU–peripheral IOT path.
- Takes an IOT instruction from the CPU, decodes the device select and the IOP bits, and issues timed IOP1/IOP2/IOP4 pulses to NDEV peripherals.
- Collects the peripherals' skip, data and clear-AC responses and hands the CPU one merged result with a done pulse.
- Owns the program-interrupt enable (device 00 IOTs) and raises the interrupt request to the CPU.

Parameters:
NDEV, 4, number of peripheral response slots.
PULSE_CYCLES, 1, clock cycles each IOP phase lasts (1..15).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
iot_start  input  1  one-cycle pulse from CPU: instruction is valid, begin IOT
instruction  input  [0:11]  current instruction, held stable until iot_done
instr_done  input  1  one-cycle pulse at end of every instruction
int_ack  input  1  CPU is taking the interrupt
dev_skip  input  NDEV  per-device skip response
dev_data  input  NDEV*12  per-device data, slot k at bits [12k+11:12k]
dev_data_valid  input  NDEV  slot k is driving dev_data this cycle
dev_clr_ac  input  NDEV  slot k requests AC clear
dev_irq  input  NDEV  per-device interrupt request levels
dev_select  output  [0:5]  device code, instruction[3:8]
iop1  output  1  IOP1 pulse
iop2  output  1  IOP2 pulse
iop4  output  1  IOP4 pulse
busy  output  1  sequence in progress
iot_done  output  1  one-cycle pulse; result outputs are valid
skip  output  1  merged skip result
clear_ac  output  1  merged clear-AC result
in_bus  output  [0:11]  merged data result (OR of latched data)
int_enable  output  1  interrupt enable flip-flop
int_req  output  1  interrupt request to CPU

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0; ion_delay 0; phase counter 0.
- Start acceptance:
  - iot_start is accepted only in IDLE and only when instruction[0:2]==3'o6.
  - Otherwise it is ignored: no busy, no done.
  - dev_select is registered from instruction[3:8] on acceptance and held until the next acceptance.
- States: IDLE, P1, P2, P4, DONE.
- Device code != 00:
  - Accepted start -> P1 -> P2 -> P4 -> DONE -> IDLE.
  - Each Pn state lasts PULSE_CYCLES cycles.
  - iopN is high for every cycle of state Pn only if its bit is set: bit 11 = IOP1, bit 10 = IOP2, bit 9 = IOP4.
  - All three phases are traversed even when their bit is 0, so timing is fixed.
- Device code 00: start -> DONE directly; no IOP pulses.
- On start acceptance, the skip, clear_ac and in_bus accumulators clear to 0.
- Response capture, during any cycle in P1/P2/P4 whose iopN is high:
  - skip |= |dev_skip
  - clear_ac |= |dev_clr_ac
  - in_bus |= OR of dev_data slots whose dev_data_valid is set.
  - Responses in cycles with no active iop are ignored.
- Merge rules: multiple valid slots are ORed bitwise (PDP-8 bus semantics); there is no priority.
- DONE: one cycle. iot_done=1 and busy=0; busy=1 in P1/P2/P4. Results hold until the next accepted start.
- Latency: start edge to iot_done is 3*PULSE_CYCLES+1 cycles for devices; 1 cycle for device 00.
- Device 00 ops, executed in the DONE cycle:
  - 6000 SKON: skip=int_enable, then int_enable=0.
  - 6001 ION: ion_delay=1.
  - 6002 IOF: int_enable=0 and ion_delay=0.
  - 6003 SRQ: skip=|dev_irq.
  - 6004–6007: no internal action; result is 0.
- ION delay:
  - When ion_delay=1, the first instr_done strictly after the ION's DONE cycle sets int_enable=1 and clears ion_delay.
  - instr_done in the same cycle as DONE does not count.
- int_req = int_enable & |dev_irq & ~busy, registered (one-cycle lag).
- int_ack clears int_enable and ion_delay. When int_ack coincides with ION/IOF, int_ack wins.
- iot_start arriving while busy or in DONE is dropped; there is no queueing.

Test Plan:
- PULSE_CYCLES=1, 6031 start; slot0 skip=1 during IOP1 -> iop1 high exactly cycle 1; iop2/iop4 never high; iot_done at cycle 4; skip=1; in_bus=0000.
- 6036 start; slot1 data 0215 valid in IOP2 and slot2 data 0040 valid in IOP4 -> iop2 cycle 2, iop4 cycle 3; in_bus=0255; clear_ac=1 if slot1 asserts dev_clr_ac in IOP2.
- Data valid while iop is low (IOP1 phase of 6034) -> ignored; in_bus=0000.
- 6001, then instr_done in the DONE cycle, then dev_irq=0001 -> int_enable stays 0; the next instr_done sets int_enable=1; int_req=1 one cycle later; int_ack clears both.
- SKON with int_enable=1 -> done at cycle 1, skip=1, int_enable=0. iot_start during busy -> ignored, no second done. Non-IOT 7402 start -> nothing.
- PULSE_CYCLES=3, 6047; reset asserted during P2 -> all outputs 0 immediately; no iot_done; next 6041 completes normally in 10 cycles.
